// File: rtl/ps2_kbd_pkg.sv
// ps2_kbd_pkg -- shared definitions for the PS/2 keyboard controller.
//   Register indices, STATUS/CONTROL bit positions, receiver FSM encoding
//   and the frame-validity helper used by the receiver.
package ps2_kbd_pkg;

  // CPU register indices (addr_i)
  localparam logic [1:0] REG_DATA    = 2'd0;
  localparam logic [1:0] REG_STATUS  = 2'd1;
  localparam logic [1:0] REG_CONTROL = 2'd2;
  localparam logic [1:0] REG_RSVD    = 2'd3;

  // STATUS bit positions: {IE, 4'b0, PERR, OVF, NE}
  localparam int STAT_NE   = 0;
  localparam int STAT_OVF  = 1;
  localparam int STAT_PERR = 2;
  localparam int STAT_IE   = 7;

  // CONTROL bit positions
  localparam int CTRL_FLUSH = 0;
  localparam int CTRL_IE    = 7;

  // Receiver FSM encoding
  typedef enum logic [1:0] {
    RX_IDLE   = 2'd0,
    RX_DATA   = 2'd1,
    RX_PARITY = 2'd2,
    RX_STOP   = 2'd3
  } rx_state_t;

  // A frame is good when data+parity has odd weight and the stop bit is 1.
  function automatic logic frame_ok(input logic [7:0] data,
                                    input logic       parity,
                                    input logic       stop);
    return (^{data, parity}) & stop;
  endfunction

endpackage

// File: rtl/ps2_kbd_fifo.sv
// ps2_kbd_fifo -- synchronous scan-code FIFO with count-based full/empty.
//   clk_cpu : clock
//   rst     : asynchronous active-high reset (empties the FIFO)
//   flush   : synchronous clear, wins over push/pop
//   push    : write wdata (accepted when not full, or full with a pop)
//   pop     : drop the head entry (ignored when empty)
//   head    : current head entry
//   empty, full : occupancy flags
//   drop    : pulses when a push was refused because the FIFO was full
module ps2_kbd_fifo #(
  parameter int DEPTH = 8
) (
  input  logic       clk_cpu,
  input  logic       rst,
  input  logic       flush,
  input  logic       push,
  input  logic [7:0] wdata,
  input  logic       pop,
  output logic [7:0] head,
  output logic       empty,
  output logic       full,
  output logic       drop
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   count_reg;
  logic          do_pop;
  logic          do_push;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == FULL_CNT);
  assign do_pop  = pop & ~empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign do_push = push & (~full | do_pop);
  assign drop    = push & ~do_push & ~flush;
  assign head    = mem[rd_ptr_reg];

  always_ff @(posedge clk_cpu or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_reg + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

  // Storage carries no reset; only the pointers define validity.
  always_ff @(posedge clk_cpu) begin
    if (do_push && !flush) mem[wr_ptr_reg] <= wdata;
  end

endmodule

// File: rtl/ps2_kbd_ctrl.sv
// ps2_kbd_ctrl -- PS/2 keyboard receiver with CPU register window.
//   clk_i, rst_i             : CPU clock, asynchronous active-high reset
//   ps2_clk_i, ps2_data_i    : raw asynchronous PS/2 lines
//   en_i, we_i, addr_i, din_i: register access (0 DATA, 1 STATUS, 2 CONTROL)
//   dout_o                   : registered read data (1-cycle latency)
//   irq_o                    : level interrupt request
// Optional feature: define PS2_KBD_IRQ_EN to implement IE and irq_o;
// otherwise irq_o is tied low and IE reads as 0.
module ps2_kbd_ctrl
  import ps2_kbd_pkg::*;
#(
  parameter int FIFO_DEPTH  = 8,
  parameter int FILT_LEN    = 4,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  input  logic       en_i,
  input  logic       we_i,
  input  logic [1:0] addr_i,
  input  logic [7:0] din_i,
  output logic [7:0] dout_o,
  output logic       irq_o
);

  localparam int FW = $clog2(FILT_LEN + 1);
  localparam logic [FW-1:0] FILT_LAST = FW'(FILT_LEN - 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

  // ---- 2-FF synchronizers, bit 0 = PS/2 clock, bit 1 = PS/2 data ----
  logic [1:0] line_raw;
  logic [1:0] line_sync;
  assign line_raw = {ps2_data_i, ps2_clk_i};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_sync
      logic meta_reg;
      logic sync_reg;
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          meta_reg <= 1'b1;
          sync_reg <= 1'b1;
        end else begin
          meta_reg <= line_raw[gi];
          sync_reg <= meta_reg;
        end
      end
      assign line_sync[gi] = sync_reg;
    end
  endgenerate

  // ---- clock filter and falling-edge strobe ----
  logic          filt_clk_reg;
  logic [FW-1:0] filt_cnt_reg;
  logic          strobe_reg;
  logic          bit_reg;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      filt_clk_reg <= 1'b1;
      filt_cnt_reg <= '0;
      strobe_reg   <= 1'b0;
      bit_reg      <= 1'b1;
    end else begin
      strobe_reg <= 1'b0;
      if (line_sync[0] == filt_clk_reg) begin
        filt_cnt_reg <= '0;
      end else if (filt_cnt_reg == FILT_LAST) begin
        // FILT_LEN consecutive samples disagree: accept the new level.
        filt_clk_reg <= line_sync[0];
        filt_cnt_reg <= '0;
        strobe_reg   <= filt_clk_reg;  // only a 1->0 change strobes
        bit_reg      <= line_sync[1];
      end else begin
        filt_cnt_reg <= filt_cnt_reg + 1'b1;
      end
    end
  end

  // ---- receiver FSM ----
  rx_state_t     state_reg, state_next;
  logic [7:0]    shift_reg, shift_next;
  logic [2:0]    bit_cnt_reg, bit_cnt_next;
  logic          parity_reg, parity_next;
  logic [TW-1:0] tmo_cnt_reg, tmo_cnt_next;
  logic          rx_push;
  logic          rx_err;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg   <= RX_IDLE;
      shift_reg   <= '0;
      bit_cnt_reg <= '0;
      parity_reg  <= 1'b0;
      tmo_cnt_reg <= '0;
    end else begin
      state_reg   <= state_next;
      shift_reg   <= shift_next;
      bit_cnt_reg <= bit_cnt_next;
      parity_reg  <= parity_next;
      tmo_cnt_reg <= tmo_cnt_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    shift_next   = shift_reg;
    bit_cnt_next = bit_cnt_reg;
    parity_next  = parity_reg;
    tmo_cnt_next = '0;
    rx_push      = 1'b0;
    rx_err       = 1'b0;

    case (state_reg)
      RX_IDLE: begin
        if (strobe_reg && !bit_reg) begin
          state_next   = RX_DATA;
          bit_cnt_next = '0;
        end
      end
      RX_DATA: begin
        if (strobe_reg) begin
          shift_next   = {bit_reg, shift_reg[7:1]};  // LSB arrives first
          bit_cnt_next = bit_cnt_reg + 1'b1;
          if (bit_cnt_reg == 3'd7) state_next = RX_PARITY;
        end
      end
      RX_PARITY: begin
        if (strobe_reg) begin
          parity_next = bit_reg;
          state_next  = RX_STOP;
        end
      end
      RX_STOP: begin
        if (strobe_reg) begin
          state_next = RX_IDLE;
          if (frame_ok(shift_reg, parity_reg, bit_reg)) rx_push = 1'b1;
          else                                          rx_err  = 1'b1;
        end
      end
      default: state_next = RX_IDLE;
    endcase

    // Silence inside a frame abandons it quietly.
    if (state_reg != RX_IDLE && !strobe_reg) begin
      if (tmo_cnt_reg == TMO_LAST) state_next = RX_IDLE;
      else                         tmo_cnt_next = tmo_cnt_reg + 1'b1;
    end
  end

  // ---- FIFO ----
  logic       rd_cycle;
  logic       fifo_pop;
  logic       fifo_flush;
  logic       fifo_empty;
  logic       fifo_full;
  logic       fifo_drop;
  logic [7:0] fifo_head;
  logic       wr_status;
  logic       wr_ctrl;

  assign rd_cycle   = en_i & ~we_i;
  assign fifo_pop   = rd_cycle & (addr_i == REG_DATA);
  assign wr_status  = en_i & we_i & (addr_i == REG_STATUS);
  assign wr_ctrl    = en_i & we_i & (addr_i == REG_CONTROL);
  assign fifo_flush = wr_ctrl & din_i[CTRL_FLUSH];

  ps2_kbd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_cpu (clk_i),
    .rst     (rst_i),
    .flush   (fifo_flush),
    .push    (rx_push),
    .wdata   (shift_reg),
    .pop     (fifo_pop),
    .head    (fifo_head),
    .empty   (fifo_empty),
    .full    (fifo_full),
    .drop    (fifo_drop)
  );

  // ---- sticky flags, a new event wins over a same-cycle clear ----
  logic ovf_reg;
  logic perr_reg;
  logic ie_bit;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ovf_reg  <= 1'b0;
      perr_reg <= 1'b0;
    end else begin
      if (fifo_drop)                           ovf_reg  <= 1'b1;
      else if (wr_status && din_i[STAT_OVF])   ovf_reg  <= 1'b0;
      if (rx_err)                              perr_reg <= 1'b1;
      else if (wr_status && din_i[STAT_PERR])  perr_reg <= 1'b0;
    end
  end

  // ---- read path ----
  logic [7:0] status_val;
  logic [7:0] dout_reg;

  always_comb begin
    status_val            = '0;
    status_val[STAT_NE]   = ~fifo_empty;
    status_val[STAT_OVF]  = ovf_reg;
    status_val[STAT_PERR] = perr_reg;
    status_val[STAT_IE]   = ie_bit;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      dout_reg <= 8'h00;
    end else if (rd_cycle) begin
      case (addr_i)
        REG_DATA:    dout_reg <= fifo_empty ? 8'h00 : fifo_head;
        REG_STATUS:  dout_reg <= status_val;
        REG_CONTROL: dout_reg <= {ie_bit, 7'b0};
        default:     dout_reg <= 8'h00;
      endcase
    end
  end

  assign dout_o = dout_reg;

  // ---- interrupt ----
`ifdef PS2_KBD_IRQ_EN
  logic ie_reg;
  logic irq_reg;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ie_reg  <= 1'b0;
      irq_reg <= 1'b0;
    end else begin
      if (wr_ctrl) ie_reg <= din_i[CTRL_IE];
      irq_reg <= ie_reg & (~fifo_empty | ovf_reg | perr_reg);
    end
  end

  assign ie_bit = ie_reg;
  assign irq_o  = irq_reg;
`else
  assign ie_bit = 1'b0;
  assign irq_o  = 1'b0;
`endif

  // Write-data bits with no register behind them.
  logic unused_din;
  assign unused_din = ^{din_i[6:3], din_i[7], fifo_full};

endmodule
